// File: rtl/des_ip_loader_if.sv
// Byte-stream input and L0/R0 output handshakes of the DES IP loader.
// The slave modport is the loader; the master modport is whatever feeds and drains it.
interface des_ip_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] left_half;
  logic [31:0] right_half;
  logic [3:0]  fill_count;

  modport master (
    output in_valid, in_byte, out_ready,
    input  in_ready, out_valid, left_half, right_half, fill_count
  );

  modport slave (
    input  in_valid, in_byte, out_ready,
    output in_ready, out_valid, left_half, right_half, fill_count
  );
endinterface

// File: rtl/des_ip_loader.sv
// Collects 8 bytes into a 64-bit DES block, applies the Initial Permutation and
// holds the registered L0/R0 halves until the round datapath takes them.
module des_ip_loader #(
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           abort,
  des_ip_loader_if.slave bus
);

  typedef enum logic [1:0] {
    RST_IDLE = 2'd0,
    LOAD     = 2'd1,
    HOLD     = 2'd2
  } state_t;

  // Zero-based source bit for each permuted bit: Y[i] = X[IP_TABLE[i]].
  localparam logic [5:0] IP_TABLE [64] = '{
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,
    6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,
    6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21, 6'd13, 6'd5,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15, 6'd7,
    6'd56, 6'd48, 6'd40, 6'd32, 6'd24, 6'd16, 6'd8,  6'd0,
    6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18, 6'd10, 6'd2,
    6'd60, 6'd52, 6'd44, 6'd36, 6'd28, 6'd20, 6'd12, 6'd4,
    6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22, 6'd14, 6'd6
  };

  state_t      state_q, state_d;
  logic [3:0]  fillCount_q, fillCount_d;
  logic [55:0] shift_q, shift_d;
  logic [31:0] leftHalf_q, leftHalf_d;
  logic [31:0] rightHalf_q, rightHalf_d;
  logic        inReady_q, inReady_d;
  logic        outValid_q, outValid_d;

  logic [63:0] blockMsb;
  logic [63:0] blockX;
  logic [63:0] permuted;

  // Oldest byte sits at the top of the shifter, so appending the live byte gives arrival order.
  always_comb begin
    blockMsb = {shift_q, bus.in_byte};
    blockX   = blockMsb;
    if (LSB_FIRST) begin
      for (int k = 0; k < 8; k++) begin
        blockX[8*k +: 8] = blockMsb[56-8*k +: 8];
      end
    end
    permuted = '0;
    for (int i = 0; i < 64; i++) begin
      permuted[6'(i)] = blockX[IP_TABLE[6'(i)]];
    end
  end

  always_comb begin
    state_d     = state_q;
    fillCount_d = fillCount_q;
    shift_d     = shift_q;
    leftHalf_d  = leftHalf_q;
    rightHalf_d = rightHalf_q;

    unique case (state_q)
      RST_IDLE: begin
        state_d     = LOAD;
        fillCount_d = 4'd0;
      end
      LOAD: begin
        if (abort) begin
          fillCount_d = 4'd0;
        end else if (bus.in_valid && inReady_q) begin
          shift_d = {shift_q[47:0], bus.in_byte};
          if (fillCount_q == 4'd7) begin
            state_d     = HOLD;
            fillCount_d = 4'd8;
            leftHalf_d  = permuted[63:32];
            rightHalf_d = permuted[31:0];
          end else begin
            fillCount_d = fillCount_q + 4'd1;
          end
        end
      end
      HOLD: begin
        if (abort || bus.out_ready) begin
          state_d     = LOAD;
          fillCount_d = 4'd0;
        end
      end
      default: begin
        state_d     = RST_IDLE;
        fillCount_d = 4'd0;
      end
    endcase

    // Handshake flags are registered from the next state so they line up with it.
    inReady_d  = (state_d == LOAD);
    outValid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_IDLE;
      fillCount_q <= 4'd0;
      shift_q     <= '0;
      leftHalf_q  <= '0;
      rightHalf_q <= '0;
      inReady_q   <= 1'b0;
      outValid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fillCount_q <= fillCount_d;
      shift_q     <= shift_d;
      leftHalf_q  <= leftHalf_d;
      rightHalf_q <= rightHalf_d;
      inReady_q   <= inReady_d;
      outValid_q  <= outValid_d;
    end
  end

  assign bus.in_ready   = inReady_q;
  assign bus.out_valid  = outValid_q;
  assign bus.left_half  = leftHalf_q;
  assign bus.right_half = rightHalf_q;
  assign bus.fill_count = fillCount_q;

endmodule

// File: doc/des_ip_loader.md
# des_ip_loader

Input-side counterpart of the DES final permutation stage. Accepts a 64-bit plaintext/ciphertext block as 8 bytes over a valid/ready stream, applies the DES Initial Permutation (IP), and presents the registered halves L0/R0 to the round datapath over a second valid/ready handshake. It uses the same bit-numbering convention as the final permutation stage, so IP followed by the final permutation is the identity.

## Interface
- `LSB_FIRST`, default 0: byte order. 0: first accepted byte → X[63:56], last → X[7:0]. 1: first byte → X[7:0], last → X[63:56].
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `abort`  in  1  synchronous flush of partial load or held output.
- `in_valid`  in  1  byte-stream valid.
- `in_ready`  out  1  byte-stream ready (registered).
- `in_byte`  in  8  data byte.
- `out_valid`  out  1  L0/R0 valid (registered).
- `out_ready`  in  1  round datapath accepts L0/R0.
- `left_half`  out  32  Y[63:32] of the permuted block.
- `right_half`  out  32  Y[31:0] of the permuted block.
- `fill_count`  out  4  bytes captured in the current block, 0..8.

## Operation
- Bit convention: DES bit k (1..64) is X[k-1]. Permuted word Y[i] = X[IP[i]-1], i = 0..63.
- IP table, entries 0..63: 58 50 42 34 26 18 10 2, 60 52 44 36 28 20 12 4, 62 54 46 38 30 22 14 6, 64 56 48 40 32 24 16 8, 57 49 41 33 25 17 9 1, 59 51 43 35 27 19 11 3, 61 53 45 37 29 21 13 5, 63 55 47 39 31 23 15 7.
- States:
  - RST_IDLE: entered on reset; goes to LOAD on the next clock.
  - LOAD: in_ready=1. Each in_valid&&in_ready cycle stores the byte and increments fill_count.
  - HOLD: out_valid=1, in_ready=0.
- LOAD → HOLD on the cycle the 8th byte is accepted. The IP is computed combinationally from the 7 stored bytes plus the incoming byte and registered into left_half/right_half on that same edge.
- HOLD → LOAD on out_valid&&out_ready. fill_count clears to 0 on that edge.
- left_half/right_half hold their value until the next 8th-byte capture and are never cleared by abort.
- abort (any state except reset):
  - next state is LOAD, fill_count=0, out_valid=0, partial bytes discarded.
  - abort takes priority over a simultaneous input or output handshake: the byte is dropped and the block is not consumed.
- in_valid is ignored outside LOAD. in_byte is don't-care when in_valid=0.
- Reset mid-operation discards all state immediately (asynchronous).

## Timing
- Reset values:
  - in_ready=0, out_valid=0, left_half=0, right_half=0, fill_count=0, state RST_IDLE.
  - in_ready rises on the first clock edge after rst_n deasserts.
- Latency: out_valid is high in the cycle after the 8th input handshake.
- in_ready falls in that same cycle. No bubble is inserted between bytes within a block.
- Throughput: minimum 9 cycles per block (8 LOAD + 1 HOLD), with out_ready tied high.
- in_ready returns high in the cycle after the output handshake.
- Output stability: while out_valid=1 and out_ready=0, left_half/right_half are stable.
- Gaps: in_valid may deassert between bytes for any number of cycles; fill_count holds.

## Test plan
- Last byte 0x01, others 0x00 (LSB_FIRST=0, X=64'h1) → after 8 handshakes, next cycle out_valid=1, left_half=32'h00000080, right_half=32'h00000000.
- First byte 0x80, others 0x00 (X=64'h8000_0000_0000_0000) → left_half=0, right_half=32'h01000000. Same with X=64'h2 → right_half=32'h00000080, left_half=0.
- All bytes 0xFF, out_ready held low for 5 cycles → outputs 32'hFFFFFFFF/32'hFFFFFFFF, stable. in_ready=0 throughout. in_ready=1 the cycle after out_ready rises.
- abort after 5 bytes → fill_count=0 next cycle. Then 8 new bytes for X=64'h1 → left_half=32'h00000080, with no contamination from the aborted bytes.
- Simultaneous abort with the 8th byte → out_valid stays 0, fill_count=0. abort during HOLD → out_valid drops and halves retain their value.
- rst_n pulsed low mid-load (after 3 bytes) → all outputs at reset values asynchronously. in_ready=1 one edge after release. A full 8-byte load then completes normally.
- Round-trip check: feed 200 random blocks, pass left_half/right_half through the final permutation stage, and compare with the assembled X. Repeat with LSB_FIRST=1.
